// File: rtl/sound_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sound_req_arbiter
// Brief    : Fixed-priority arbiter sharing one sound conduit between alarm,
//            entry chime and exit chime, with tick-timed tones and silent gaps.
//            Optional macro SOUND_PREEMPT_EN lets a higher-priority request
//            preempt a playing tone.
// Revision : 1.0 - initial release
// ============================================================================
module sound_req_arbiter #(
    parameter int TICK_DIV  = 50000,
    parameter int GAP_TICKS = 20
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  req_i,
    input  logic [23:0] level_i,
    input  logic [47:0] dur_i,
    input  logic        mute_i,
    output logic [2:0]  ack_o,
    output logic [2:0]  done_o,
    output logic [2:0]  abort_o,
    output logic        busy_o,
    output logic [7:0]  amount_o,
    output logic        soundenable_o
);

    localparam int              TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int              GW       = $clog2(GAP_TICKS + 1);
    localparam logic [TW-1:0]   TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [GW-1:0]   GAP_LOAD = GW'(GAP_TICKS);
    localparam logic [GW-1:0]   GAP_ONE  = GW'(1);

    localparam logic [1:0]      ST_IDLE  = 2'd0;
    localparam logic [1:0]      ST_PLAY  = 2'd1;
    localparam logic [1:0]      ST_GAP   = 2'd2;

    logic [1:0]    state_q,   state_d;
    logic [1:0]    owner_q,   owner_d;
    logic [7:0]    amt_q,     amt_d;
    logic [15:0]   dur_cnt_q, dur_cnt_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          zdone_q,   zdone_d;
    logic [2:0]    ack_q,     ack_d;
    logic [2:0]    done_q,    done_d;
    logic          snd_en_q,  snd_en_d;
`ifdef SOUND_PREEMPT_EN
    logic [2:0]    abort_q,   abort_d;
`endif

    logic [1:0]    win;
    logic          any_req;
    logic [7:0]    win_level;
    logic [15:0]   win_dur;
    logic          tick_wrap;
    logic          grant;

    function automatic logic [2:0] onehot(input logic [1:0] idx);
        onehot = 3'b001 << idx;
    endfunction

    // Fixed priority: alarm (bit2) > entry (bit1) > exit (bit0).
    always_comb begin
        win = 2'd0;
        if (req_i[2]) begin
            win = 2'd2;
        end else if (req_i[1]) begin
            win = 2'd1;
        end
        any_req   = |req_i;
        win_level = level_i[{win, 3'b000} +: 8];
        win_dur   = dur_i[{win, 4'b0000} +: 16];
        tick_wrap = (tick_cnt_q == TICK_MAX);
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= 2'd0;
            amt_q      <= 8'h00;
            dur_cnt_q  <= 16'd0;
            tick_cnt_q <= '0;
            gap_cnt_q  <= '0;
            zdone_q    <= 1'b0;
            ack_q      <= 3'b000;
            done_q     <= 3'b000;
            snd_en_q   <= 1'b0;
`ifdef SOUND_PREEMPT_EN
            abort_q    <= 3'b000;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            amt_q      <= amt_d;
            dur_cnt_q  <= dur_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            zdone_q    <= zdone_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            snd_en_q   <= snd_en_d;
`ifdef SOUND_PREEMPT_EN
            abort_q    <= abort_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        amt_d      = amt_q;
        dur_cnt_d  = dur_cnt_q;
        tick_cnt_d = tick_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        zdone_d    = 1'b0;
        ack_d      = 3'b000;
        done_d     = 3'b000;
        grant      = 1'b0;
`ifdef SOUND_PREEMPT_EN
        abort_d    = 3'b000;
`endif

        case (state_q)
            ST_IDLE: begin
                // A zero-length tone stays in IDLE for its ack cycle, then reports done.
                if (zdone_q) begin
                    done_d = onehot(owner_q);
                end else begin
                    grant = any_req;
                end
            end
            ST_PLAY: begin
                tick_cnt_d = tick_wrap ? '0 : tick_cnt_q + 1'b1;
                if (tick_wrap) begin
                    dur_cnt_d = dur_cnt_q - 16'd1;
                end
                if (tick_wrap && (dur_cnt_q == 16'd1)) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = GAP_LOAD;
                    done_d    = onehot(owner_q);
                end
`ifdef SOUND_PREEMPT_EN
                else if (any_req && (win > owner_q)) begin
                    grant   = 1'b1;
                    abort_d = onehot(owner_q);
                end
`endif
            end
            ST_GAP: begin
                tick_cnt_d = tick_wrap ? '0 : tick_cnt_q + 1'b1;
                if (tick_wrap) begin
                    gap_cnt_d = gap_cnt_q - GAP_ONE;
                end
                // Arbitrate on the closing edge so the next tone follows the
                // gap with no extra idle cycle.
                if (tick_wrap && (gap_cnt_q == GAP_ONE)) begin
                    state_d = ST_IDLE;
                    grant   = any_req;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (grant) begin
            ack_d      = onehot(win);
            owner_d    = win;
            amt_d      = win_level;
            dur_cnt_d  = win_dur;
            tick_cnt_d = '0;
            if (win_dur == 16'd0) begin
                state_d = ST_IDLE;
                zdone_d = 1'b1;
            end else begin
                state_d = ST_PLAY;
            end
        end
    end

    // Output logic
    always_comb begin
        snd_en_d = (state_d == ST_PLAY) & ~mute_i;
        amount_o = (state_q == ST_PLAY) ? amt_q : 8'h00;
        busy_o   = (state_q != ST_IDLE) | zdone_q;
    end

    assign ack_o         = ack_q;
    assign done_o        = done_q;
    assign soundenable_o = snd_en_q;
`ifdef SOUND_PREEMPT_EN
    assign abort_o       = abort_q;
`else
    assign abort_o       = 3'b000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sound_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sound_req_arbiter
// Brief    : Directed plus randomized bench for sound_req_arbiter against a
//            cycle-timeline reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sound_req_arbiter;

    localparam int TD = 4;
    localparam int GT = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  req_i = 3'b000;
    logic [23:0] level_i = 24'h0;
    logic [47:0] dur_i = 48'h0;
    logic        mute_i = 1'b0;
    logic [2:0]  ack_o;
    logic [2:0]  done_o;
    logic [2:0]  abort_o;
    logic        busy_o;
    logic [7:0]  amount_o;
    logic        soundenable_o;

    sound_req_arbiter #(
        .TICK_DIV  (TD),
        .GAP_TICKS (GT)
    ) u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_i         (req_i),
        .level_i       (level_i),
        .dur_i         (dur_i),
        .mute_i        (mute_i),
        .ack_o         (ack_o),
        .done_o        (done_o),
        .abort_o       (abort_o),
        .busy_o        (busy_o),
        .amount_o      (amount_o),
        .soundenable_o (soundenable_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n     = 0;

    // Timeline of the current tone, in absolute cycle numbers.
    int       t_start, play_last, busy_last, ack_cyc, done_cyc, abort_cyc, arb_from;
    int       owner, done_own, abort_own;
    logic [7:0] m_amt;
    logic     mute_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, n, obs, exp);
        end
    endtask

    task automatic model_reset();
        t_start   = 0;
        play_last = -1;
        busy_last = -1;
        ack_cyc   = -1;
        done_cyc  = -1;
        abort_cyc = -1;
        arb_from  = n;
        owner     = 0;
        done_own  = 0;
        abort_own = 0;
        m_amt     = 8'h00;
        mute_e    = 1'b0;
    endtask

    // Evaluate the decision taken at the edge closing cycle n.
    task automatic model_edge();
        int win;
        int d;
        bit grant;
        bit pre;
        mute_e = mute_i;
        win    = req_i[2] ? 2 : (req_i[1] ? 1 : 0);
        grant  = 1'b0;
        pre    = 1'b0;
        if (req_i != 3'b000 && n >= arb_from) grant = 1'b1;
`ifdef SOUND_PREEMPT_EN
        else if (req_i != 3'b000 && n >= t_start && n < play_last && win > owner) begin
            grant = 1'b1;
            pre   = 1'b1;
        end
`endif
        if (grant) begin
            if (pre) begin
                abort_cyc = n + 1;
                abort_own = owner;
            end
            owner    = win;
            done_own = win;
            m_amt    = level_i[8*win +: 8];
            d        = int'(dur_i[16*win +: 16]);
            ack_cyc  = n + 1;
            t_start  = n + 1;
            if (d == 0) begin
                play_last = n;
                done_cyc  = n + 2;
                busy_last = n + 1;
                arb_from  = n + 2;
            end else begin
                play_last = n + d * TD;
                done_cyc  = play_last + 1;
                busy_last = play_last + GT * TD;
                arb_from  = busy_last;
            end
        end
    endtask

    task automatic check_outputs();
        bit in_play;
        in_play = (n >= t_start) && (n <= play_last);
        check("ack",   32'(ack_o),   (n == ack_cyc)   ? 32'(1 << owner)     : 32'd0);
        check("done",  32'(done_o),  (n == done_cyc)  ? 32'(1 << done_own)  : 32'd0);
        check("abort", 32'(abort_o), (n == abort_cyc) ? 32'(1 << abort_own) : 32'd0);
        check("busy",  32'(busy_o),  32'((n >= t_start) && (n <= busy_last)));
        check("amount", 32'(amount_o), in_play ? 32'(m_amt) : 32'd0);
        check("sound_en", 32'(soundenable_o), 32'(in_play && !mute_e));
    endtask

    task automatic requesters(input bit rnd);
        for (int i = 0; i < 3; i++) begin
            if (n == ack_cyc && owner == i) begin
                req_i[i] = 1'b0;
            end else if (rnd) begin
                if (req_i[i] && $urandom_range(0, 29) == 0) req_i[i] = 1'b0;
                else if (!req_i[i] && $urandom_range(0, 9) == 0) req_i[i] = 1'b1;
            end
        end
        if (rnd) begin
            level_i = 24'($urandom);
            for (int i = 0; i < 3; i++) dur_i[16*i +: 16] = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) mute_i = ~mute_i;
        end
    endtask

    task automatic step(input bit rnd);
        @(posedge clk);
        if (reset_n) model_edge();
        n++;
        #1;
        check_outputs();
        requesters(rnd);
    endtask

    initial begin
        int a;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs();

        // Single exit tone
        level_i = 24'h000040;
        dur_i   = {16'd0, 16'd0, 16'd3};
        req_i   = 3'b001;
        reset_n = 1'b1;
        repeat (30) step(1'b0);

        // All three at once
        level_i = 24'hC08020;
        dur_i   = {16'd2, 16'd2, 16'd2};
        req_i   = 3'b111;
        repeat (60) step(1'b0);

        // Zero-duration entry chime
        level_i[15:8] = 8'h55;
        dur_i[31:16]  = 16'd0;
        req_i         = 3'b010;
        repeat (6) step(1'b0);

        // Mute across ticks 2-3 of an alarm tone
        level_i[23:16] = 8'hA5;
        dur_i[47:32]   = 16'd5;
        req_i          = 3'b100;
        step(1'b0);
        a = n;
        repeat (32) begin
            mute_i = (n >= a + 3) && (n <= a + 10);
            step(1'b0);
        end
        mute_i = 1'b0;

        // Alarm arriving while exit plays
        level_i = 24'hEE0011;
        dur_i   = {16'd2, 16'd0, 16'd4};
        req_i   = 3'b001;
        repeat (6) step(1'b0);
        req_i[2] = 1'b1;
        repeat (50) step(1'b0);

        // Reset in the middle of a tone
        level_i = 24'h003377;
        dur_i   = {16'd0, 16'd2, 16'd4};
        req_i   = 3'b001;
        repeat (6) step(1'b0);
        reset_n = 1'b0;
        req_i   = 3'b000;
        #1;
        check("rst_ack",    32'(ack_o),         32'd0);
        check("rst_done",   32'(done_o),        32'd0);
        check("rst_abort",  32'(abort_o),       32'd0);
        check("rst_busy",   32'(busy_o),        32'd0);
        check("rst_amount", 32'(amount_o),      32'd0);
        check("rst_snd",    32'(soundenable_o), 32'd0);
        repeat (2) @(posedge clk);
        n += 2;
        #1;
        model_reset();
        check_outputs();
        reset_n = 1'b1;
        req_i   = 3'b010;
        repeat (30) step(1'b0);

        // Randomized traffic
        repeat (3000) step(1'b1);
        req_i = 3'b000;
        repeat (40) step(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
